// File: rtl/sound_scheduler.sv
// Speaker arbiter for the digital clock: chime > alarm > key beep, with alarm
// ring/cadence timing, beep timing and square-wave synthesis from the 1 kHz clock.
module sound_scheduler #(
  parameter int ALARM_MS   = 60000,
  parameter int BEEP_MS    = 50,
  parameter int CADENCE_ON = 500
) (
  input  logic       CP_1Khz,
  input  logic       nCR,
  input  logic       Low_sound,
  input  logic       High_sound,
  input  logic       alarm_hit,
  input  logic       alarm_stop,
  input  logic       key_beep,
  input  logic       mute,
  output logic       Speaker,
  output logic [1:0] src,
  output logic       alarm_active,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALARM = 2'd1,
    S_BEEP  = 2'd2
  } state_e;

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_CHIME = 2'd1;
  localparam logic [1:0] SRC_ALARM = 2'd2;
  localparam logic [1:0] SRC_BEEP  = 2'd3;

  localparam logic [15:0] RING_LAST = 16'(ALARM_MS - 1);
  localparam logic [9:0]  BEEP_LAST = 10'(BEEP_MS - 1);
  localparam logic [9:0]  CAD_LAST  = 10'd999;
  localparam logic [9:0]  CAD_ON    = 10'(CADENCE_ON);

  state_e      state_q, state_d;
  logic [15:0] ring_q, ring_d;
  logic [9:0]  beep_q, beep_d;
  logic [9:0]  cad_q, cad_d;
  logic [1:0]  phase_q, phase_d;
  logic [1:0]  src_q, src_d;
  logic        spk_q, spk_d;
  logic        hit_q, stop_q;
  logic        hit_rise, stop_rise;

  // History resets to 1 so a level already high at reset release is not an edge.
  assign hit_rise  = alarm_hit & ~hit_q;
  assign stop_rise = alarm_stop & ~stop_q;

  always_comb begin
    state_d = state_q;
    ring_d  = '0;
    beep_d  = '0;
    cad_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (hit_rise)      state_d = S_ALARM;
        else if (key_beep) state_d = S_BEEP;
      end
      S_ALARM: begin
        if (stop_rise) begin
          state_d = S_IDLE;
        end else if (hit_rise) begin
          ring_d = '0;
          cad_d  = (cad_q == CAD_LAST) ? 10'd0 : cad_q + 10'd1;
        end else if (ring_q == RING_LAST) begin
          state_d = S_IDLE;
        end else begin
          ring_d = ring_q + 16'd1;
          cad_d  = (cad_q == CAD_LAST) ? 10'd0 : cad_q + 10'd1;
        end
      end
      S_BEEP: begin
        if (hit_rise)                 state_d = S_ALARM;
        else if (key_beep)            beep_d  = '0;
        else if (beep_q == BEEP_LAST) state_d = S_IDLE;
        else                          beep_d  = beep_q + 10'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Owner and tone are decided from the next state so they land on the same edge.
  always_comb begin
    src_d = SRC_NONE;
    if (Low_sound | High_sound) src_d = SRC_CHIME;
    else if (state_d == S_ALARM) src_d = SRC_ALARM;
    else if (state_d == S_BEEP)  src_d = SRC_BEEP;

    phase_d = (src_d != src_q) ? 2'd0 : phase_q + 2'd1;

    spk_d = 1'b0;
    case (src_d)
      SRC_CHIME: spk_d = High_sound ? ~phase_d[0] : ~phase_d[1];
      SRC_ALARM: spk_d = (cad_d < CAD_ON) & ~phase_d[0];
      SRC_BEEP:  spk_d = ~phase_d[0];
      default:   spk_d = 1'b0;
    endcase
    if (mute) spk_d = 1'b0;
  end

  always_ff @(posedge CP_1Khz) begin
    if (!nCR) begin
      state_q <= S_IDLE;
      ring_q  <= '0;
      beep_q  <= '0;
      cad_q   <= '0;
      phase_q <= '0;
      src_q   <= SRC_NONE;
      spk_q   <= 1'b0;
      hit_q   <= 1'b1;
      stop_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      beep_q  <= beep_d;
      cad_q   <= cad_d;
      phase_q <= phase_d;
      src_q   <= src_d;
      spk_q   <= spk_d;
      hit_q   <= alarm_hit;
      stop_q  <= alarm_stop;
    end
  end

  assign Speaker      = spk_q;
  assign src          = src_q;
  assign alarm_active = (state_q == S_ALARM);
  assign dbg_state_o  = state_q;

endmodule

// File: doc/sound_scheduler.md
Name: sound_scheduler

Overview:
- Owns the single speaker output of the digital clock and shares it between three requesters: the hourly chime (Low_sound/High_sound), the alarm comparator and the key-press beep.
- Arbitrates by fixed priority, times the alarm ring and the key beep, and synthesises the tone square waves from the 1 kHz system clock.
- Sits between the chime/alarm/keypad logic and the speaker pin driver.

Parameters:
- ALARM_MS, 60000: alarm ring duration in clock cycles (ms).
- BEEP_MS, 50: key beep duration in cycles.
- CADENCE_ON, 500: alarm tone-on cycles within each 1000-cycle period.

Ports:
- CP_1Khz  in  1  system clock, 1 kHz.
- nCR  in  1  synchronous reset, active-low.
- Low_sound  in  1  chime low-tone request (level).
- High_sound  in  1  chime high-tone request (level).
- alarm_hit  in  1  alarm time match (level; rising edge starts ring).
- alarm_stop  in  1  debounced stop key (level; rising edge acts).
- key_beep  in  1  one-cycle key press pulse.
- mute  in  1  forces Speaker low; scheduling continues.
- Speaker  out  1  registered tone output.
- src  out  2  current owner: 0 none, 1 chime, 2 alarm, 3 beep.
- alarm_active  out  1  high while in ALARM state.

Behaviour:
- Clocking and reset:
  - One clock, CP_1Khz.
  - Reset is synchronous, active-low on nCR; all registers update on the rising edge of CP_1Khz.
  - nCR=0 at an edge forces: Speaker=0, src=0, alarm_active=0, state IDLE, all counters 0, alarm_hit/alarm_stop edge-detect history registers set to 1. Setting history to 1 means a level already high at reset release causes no action.
  - Reset mid-ring or mid-beep aborts immediately.
- Tones:
  - HIGH: Speaker toggles every cycle (500 Hz).
  - LOW: Speaker toggles every 2 cycles (250 Hz).
  - The tone phase counter clears whenever src changes, so the first cycle of a new grant drives Speaker=1.
- State machine (alarm/beep):
  - IDLE:
    - Rising edge of alarm_hit -> ALARM, ring counter=0.
    - Otherwise key_beep -> BEEP, beep counter=0.
  - ALARM:
    - alarm_active=1.
    - Ring counter increments each cycle and runs even while the chime overrides the output.
    - Cadence counter 0..999 wraps; the tone is HIGH when cadence<CADENCE_ON, otherwise silent while src stays 2.
    - Exit to IDLE when the ring counter reaches ALARM_MS-1 or on a rising edge of alarm_stop.
    - A new rising edge of alarm_hit restarts the ring counter.
    - Stop and hit on the same edge: stop wins, go to IDLE.
    - key_beep is ignored.
  - BEEP:
    - HIGH tone for BEEP_MS cycles, then IDLE.
    - key_beep during BEEP restarts the counter.
    - Rising edge of alarm_hit -> ALARM (preempts).
- Arbitration, evaluated each cycle and registered, 1-cycle latency:
  - Low_sound|High_sound has highest priority -> src=1.
    - High_sound selects HIGH, else LOW.
    - If both are high, HIGH wins.
  - Else ALARM -> src=2.
  - Else BEEP -> src=3.
  - Else src=0 and Speaker=0.
- Chime override:
  - The chime does not change the state machine.
  - When the chime drops, the underlying ALARM/BEEP resumes with phase cleared.
- mute=1: Speaker=0 on the next edge; src, alarm_active and the counters behave unchanged.
- Counter widths: ALARM_MS-1 must fit in a 16-bit counter; the beep and cadence counters are 10 bits.

Test Plan:
- Reset: hold nCR=0 with alarm_hit=1, then release -> Speaker=0, src=0, alarm_active=0; no ring starts until alarm_hit falls and rises again.
- Key beep: key_beep pulse in IDLE -> src=3 on the next cycle, Speaker toggles 1,0,1,… for 50 cycles, then src=0 and Speaker=0; a second pulse at cycle 30 extends the beep to cycle 80.
- Alarm cadence and timeout (ALARM_MS=3000 for sim):
  - Tone for 500 cycles, silent for 500, over three periods.
  - alarm_active falls exactly 3000 cycles after the grant.
  - key_beep during the ring is ignored.
- Alarm stop:
  - Rising edge of alarm_stop at cycle 1200 -> alarm_active=0 and src=0 on the next edge.
  - Simultaneous alarm_hit and alarm_stop edges during ALARM -> IDLE.
- Chime preemption:
  - During ALARM, Low_sound=1 for 1000 cycles -> src=1, Speaker period 4 cycles.
  - Then High_sound alone -> period 2.
  - After the chime drops, src=2 resumes and alarm_active has stayed 1 throughout.
- Mute: mute=1 during BEEP -> Speaker held 0 while src=3; the beep still ends at 50 cycles.
